// File: rtl/measure_pkg.sv
// Constants shared by the GMII measurement TX generator and RX engine.
package measure_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VIHL      = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

    // Byte offsets counted from the first byte after the SFD.
    localparam logic [11:0] OFF_ETYPE = 12'd12;
    localparam logic [11:0] OFF_VIHL  = 12'd14;
    localparam logic [11:0] OFF_PROTO = 12'd23;
    localparam logic [11:0] OFF_MAGIC = 12'd42;
    localparam logic [11:0] OFF_TS    = 12'd46;

    localparam logic [11:0] MIN_FRAME = 12'd64;
    localparam logic [11:0] MAX_FRAME = 12'd1518;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_DROP
    } rx_state_e;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/gmii_meas_parser.sv
// GMII RX frame delimiter and measurement-frame field parser; reports one
// done/ok pulse per frame the cycle after dv falls.
module gmii_meas_parser
    import measure_pkg::*;
#(
    parameter logic [31:0] MEAS_MAGIC = 32'h4D475552
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rxd_i,
    input  logic        dv_i,
    input  logic [31:0] gcnt_i,
    output logic        frame_done_o,
    output logic        frame_ok_o,
    output logic [11:0] byte_cnt_o,
    output logic [31:0] latency_o
);

    rx_state_e   state_q, state_d;
    logic [11:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] t_sfd_q, t_sfd_d;
    logic [15:0] etype_q, etype_d;
    logic [7:0]  vihl_q, vihl_d;
    logic [7:0]  proto_q, proto_d;
    logic [31:0] magic_q, magic_d;
    logic [31:0] ts_q, ts_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic [31:0] lat_q, lat_d;
    logic        fields_ok, len_ok;

    // Fields all lie below MIN_FRAME, so a length-qualified frame has overwritten any stale capture.
    assign fields_ok = (etype_q == ETHERTYPE_IPV4) && (vihl_q == IPV4_VIHL) &&
                       (proto_q == IP_PROTO_UDP) && (magic_q == MEAS_MAGIC);
    assign len_ok    = (byte_cnt_q >= MIN_FRAME) && (byte_cnt_q <= MAX_FRAME);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        t_sfd_d    = t_sfd_q;
        etype_d    = etype_q;
        vihl_d     = vihl_q;
        proto_d    = proto_q;
        magic_d    = magic_q;
        ts_d       = ts_q;
        done_d     = 1'b0;
        ok_d       = 1'b0;
        lat_d      = lat_q;
        case (state_q)
            ST_ARM: begin
                if (!dv_i) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (dv_i) state_d = (rxd_i == 8'h55) ? ST_PRE : ST_DROP;
            end
            ST_PRE: begin
                if (!dv_i) begin
                    state_d = ST_IDLE;
                end else if (rxd_i == 8'hD5) begin
                    state_d    = ST_DATA;
                    byte_cnt_d = '0;
                    t_sfd_d    = gcnt_i;
                end else if (rxd_i != 8'h55) begin
                    state_d = ST_DROP;
                end
            end
            ST_DATA: begin
                if (dv_i) begin
                    if (byte_cnt_q != 12'hFFF) byte_cnt_d = byte_cnt_q + 12'd1;
                    if (byte_cnt_q == OFF_ETYPE || byte_cnt_q == OFF_ETYPE + 12'd1)
                        etype_d = {etype_q[7:0], rxd_i};
                    if (byte_cnt_q == OFF_VIHL)  vihl_d  = rxd_i;
                    if (byte_cnt_q == OFF_PROTO) proto_d = rxd_i;
                    if (byte_cnt_q >= OFF_MAGIC && byte_cnt_q < OFF_MAGIC + 12'd4)
                        magic_d = {magic_q[23:0], rxd_i};
                    if (byte_cnt_q >= OFF_TS && byte_cnt_q < OFF_TS + 12'd4)
                        ts_d = {ts_q[23:0], rxd_i};
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    ok_d    = fields_ok && len_ok;
                    lat_d   = t_sfd_q - ts_q;
                end
            end
            ST_DROP: begin
                if (!dv_i) state_d = ST_IDLE;
            end
            default: state_d = ST_ARM;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_ARM;
            byte_cnt_q <= '0;
            t_sfd_q    <= '0;
            etype_q    <= '0;
            vihl_q     <= '0;
            proto_q    <= '0;
            magic_q    <= '0;
            ts_q       <= '0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            lat_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            t_sfd_q    <= t_sfd_d;
            etype_q    <= etype_d;
            vihl_q     <= vihl_d;
            proto_q    <= proto_d;
            magic_q    <= magic_d;
            ts_q       <= ts_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            lat_q      <= lat_d;
        end
    end

    assign frame_done_o = done_q;
    assign frame_ok_o   = ok_q;
    assign byte_cnt_o   = byte_cnt_q;
    assign latency_o    = lat_q;

endmodule

// File: rtl/measure_rx.sv
// GMII RX measurement engine: per-window frame rate, bit rate and one-way
// latency of measurement frames.
module measure_rx
    import measure_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 125000000,
    parameter logic [31:0] MEAS_MAGIC    = 32'h4D475552
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic [31:0] global_counter,
    output logic [31:0] rx_pps,
    output logic [31:0] rx_throughput,
    output logic [31:0] rx_latency,
    output logic        rx_frame_ok
);

    logic        p_done, p_ok, accept;
    logic [11:0] p_bytes;
    logic [31:0] p_lat;

    gmii_meas_parser #(
        .MEAS_MAGIC(MEAS_MAGIC)
    ) u_parser (
        .clk_i       (sys_clk),
        .rst_i       (sys_rst),
        .rxd_i       (gmii_rxd),
        .dv_i        (gmii_rx_dv),
        .gcnt_i      (global_counter),
        .frame_done_o(p_done),
        .frame_ok_o  (p_ok),
        .byte_cnt_o  (p_bytes),
        .latency_o   (p_lat)
    );

    assign accept = p_done & p_ok;

    logic [31:0] win_cnt_q, win_cnt_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] byte_acc_q, byte_acc_d;
    logic [31:0] last_lat_q, last_lat_d;
    logic        seen_q, seen_d;
    logic [31:0] pps_q, pps_d;
    logic [31:0] thr_q, thr_d;
    logic [31:0] lat_q, lat_d;
    logic        win_end;
    logic [31:0] pkt_n, bytes_n, lat_n;
    logic        seen_n;

    assign win_end = (win_cnt_q == WINDOW_CYCLES - 32'd1);

    always_comb begin
        // Fold this cycle's acceptance in first so a coincident window load includes it.
        pkt_n      = accept ? sat_add32(pkt_cnt_q, 32'd1) : pkt_cnt_q;
        bytes_n    = accept ? sat_add32(byte_acc_q, {20'd0, p_bytes}) : byte_acc_q;
        lat_n      = accept ? p_lat : last_lat_q;
        seen_n     = seen_q | accept;

        win_cnt_d  = win_end ? 32'd0 : win_cnt_q + 32'd1;
        pkt_cnt_d  = pkt_n;
        byte_acc_d = bytes_n;
        last_lat_d = lat_n;
        seen_d     = seen_n;
        pps_d      = pps_q;
        thr_d      = thr_q;
        lat_d      = lat_q;
        if (win_end) begin
            pps_d      = pkt_n;
            thr_d      = {bytes_n[28:0], 3'b000};
            if (seen_n) lat_d = lat_n;
            pkt_cnt_d  = '0;
            byte_acc_d = '0;
            seen_d     = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            win_cnt_q  <= '0;
            pkt_cnt_q  <= '0;
            byte_acc_q <= '0;
            last_lat_q <= '0;
            seen_q     <= 1'b0;
            pps_q      <= '0;
            thr_q      <= '0;
            lat_q      <= '0;
        end else begin
            win_cnt_q  <= win_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            byte_acc_q <= byte_acc_d;
            last_lat_q <= last_lat_d;
            seen_q     <= seen_d;
            pps_q      <= pps_d;
            thr_q      <= thr_d;
            lat_q      <= lat_d;
        end
    end

    assign rx_pps        = pps_q;
    assign rx_throughput = thr_q;
    assign rx_latency    = lat_q;
    assign rx_frame_ok   = accept;

endmodule

// File: tb/tb_measure_rx.sv
// Randomized bench for measure_rx: frame-level acceptance model plus
// window bookkeeping, checked every cycle, with directed literal anchors.
module tb_measure_rx;

    localparam int          W     = 1000;
    localparam logic [31:0] MAGIC = 32'h4D475552;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic [31:0] global_counter;
    logic [31:0] rx_pps, rx_throughput, rx_latency;
    logic        rx_frame_ok;

    measure_rx #(.WINDOW_CYCLES(W), .MEAS_MAGIC(MAGIC)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .gmii_rxd      (gmii_rxd),
        .gmii_rx_dv    (gmii_rx_dv),
        .global_counter(global_counter),
        .rx_pps        (rx_pps),
        .rx_throughput (rx_throughput),
        .rx_latency    (rx_latency),
        .rx_frame_ok   (rx_frame_ok)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;
    int since_rst = 0;

    always @(posedge sys_clk) edge_n <= edge_n + 1;
    always @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) since_rst <= 0;
        else         since_rst <= since_rst + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Expected acceptance: edge after which the pulse is visible, its length and latency.
    typedef struct {
        int          e;
        int          len;
        logic [31:0] lat;
    } acc_t;
    acc_t exp_q[$];

    logic [63:0] m_pkt = 0, m_bytes = 0;
    logic [31:0] m_lat = 0;
    bit          m_any = 0;
    logic [31:0] e_pps = 0, e_thr = 0, e_lat = 0;
    bit          prev_ok = 0, e_ok;
    acc_t        prev, cur;

    always @(negedge sys_clk) begin
        e_ok = 0;
        if (sys_rst) begin
            m_pkt = 0; m_bytes = 0; m_lat = 0; m_any = 0;
            e_pps = 0; e_thr = 0; e_lat = 0;
        end else begin
            if (prev_ok) begin
                m_pkt   = m_pkt + 1;
                m_bytes = m_bytes + 64'(prev.len);
                m_lat   = prev.lat;
                m_any   = 1;
            end
            if (since_rst > 0 && since_rst % W == 0) begin
                e_pps = m_pkt[31:0];
                e_thr = 32'(m_bytes * 8);
                if (m_any) e_lat = m_lat;
                m_pkt = 0; m_bytes = 0; m_any = 0;
            end
            if (exp_q.size() > 0 && exp_q[0].e == edge_n) begin
                e_ok = 1;
                cur  = exp_q.pop_front();
            end
        end
        prev_ok = e_ok;
        prev    = cur;
        chk("frame_ok",   32'(rx_frame_ok), 32'(e_ok));
        chk("pps",        rx_pps,           e_pps);
        chk("throughput", rx_throughput,    e_thr);
        chk("latency",    rx_latency,       e_lat);
    end

    logic [7:0]  fr [0:1599];
    logic [31:0] gc;

    task automatic step(input logic [7:0] d, input logic v);
        gmii_rxd       = d;
        gmii_rx_dv     = v;
        global_counter = gc;
        gc             = gc + 32'd1;
        @(posedge sys_clk);
        #1;
    endtask

    // corrupt: 0 none, 1 ethertype, 2 version/IHL, 3 protocol, 4 magic
    task automatic send_frame(input int len, input int npre, input bit bad_pre, input int corrupt,
                              input logic [31:0] lat, input int gap,
                              input bit force_gc, input logic [31:0] gc_val);
        logic [7:0]  pre [0:7];
        logic [31:0] ts;
        bit          good;
        acc_t        a;
        for (int i = 0; i < len; i++) fr[i] = 8'($urandom);
        {fr[12], fr[13]} = 16'h0800;
        fr[14] = 8'h45;
        fr[23] = 8'h11;
        {fr[42], fr[43], fr[44], fr[45]} = MAGIC;
        case (corrupt)
            1: {fr[12], fr[13]} = 16'h86DD;
            2: fr[14] = 8'h46;
            3: fr[23] = 8'h06;
            4: {fr[42], fr[43], fr[44], fr[45]} = 32'h0;
            default: ;
        endcase
        for (int i = 0; i < npre; i++) pre[i] = 8'h55;
        if (bad_pre) pre[1] = 8'h57;
        good = (len >= 64) && (len <= 1518) && ({fr[12], fr[13]} == 16'h0800) &&
               (fr[14] == 8'h45) && (fr[23] == 8'h11) &&
               ({fr[42], fr[43], fr[44], fr[45]} == MAGIC) && (npre >= 1);
        for (int i = 0; i < npre; i++) if (pre[i] != 8'h55) good = 0;
        for (int i = 0; i < npre; i++) step(pre[i], 1'b1);
        if (force_gc) gc = gc_val;
        ts = gc - lat;
        {fr[46], fr[47], fr[48], fr[49]} = ts;
        step(8'hD5, 1'b1);
        for (int i = 0; i < len; i++) step(fr[i], 1'b1);
        if (good) begin
            a.e = edge_n + 1; a.len = len; a.lat = lat;
            exp_q.push_back(a);
        end
        step(8'h00, 1'b0);
        repeat (gap) step(8'h00, 1'b0);
    endtask

    task automatic wait_win_start();
        do step(8'h00, 1'b0); while (since_rst % W != 1);
    endtask

    initial begin
        int len, np, bp, cor, L;
        sys_rst = 1'b1;
        gmii_rxd = '0; gmii_rx_dv = 1'b0; global_counter = '0;
        gc = 32'h0000_1000;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_pps", rx_pps, 32'd0);
        chk("rst_thr", rx_throughput, 32'd0);
        chk("rst_lat", rx_latency, 32'd0);
        chk("rst_ok",  32'(rx_frame_ok), 32'd0);
        sys_rst = 1'b0;

        // Five clean 64-byte frames, latency 20.
        wait_win_start();
        repeat (5) send_frame(64, 7, 0, 0, 32'd20, 4, 0, 0);
        wait_win_start();
        chk("t1_pps", rx_pps, 32'd5);
        chk("t1_thr", rx_throughput, 32'd2560);
        chk("t1_lat", rx_latency, 32'd20);

        // Rejected frames: bad ethertype, zero magic, 63 bytes.
        send_frame(64, 7, 0, 1, 32'd99, 4, 0, 0);
        send_frame(64, 7, 0, 4, 32'd99, 4, 0, 0);
        send_frame(63, 7, 0, 0, 32'd99, 4, 0, 0);
        wait_win_start();
        chk("t2_pps", rx_pps, 32'd0);
        chk("t2_thr", rx_throughput, 32'd0);
        chk("t2_lat", rx_latency, 32'd20);

        // Timestamp wrap: t_sfd 0x10, ts 0xFFFFFFF0.
        send_frame(64, 7, 0, 0, 32'h20, 4, 1, 32'h0000_0010);
        wait_win_start();
        chk("t3_lat", rx_latency, 32'h20);
        chk("t3_pps", rx_pps, 32'd1);

        // Acceptance pulse on the window-load cycle.
        L = 7 + 1 + 64;
        while ((since_rst + L + 2) % W != 0) step(8'h00, 1'b0);
        send_frame(64, 7, 0, 0, 32'd33, 0, 0, 0);
        wait_win_start();
        chk("t4_pps", rx_pps, 32'd1);
        chk("t4_lat", rx_latency, 32'd33);
        wait_win_start();
        chk("t4_next_pps", rx_pps, 32'd0);

        // Reset in mid-DATA, released while dv is still high.
        for (int i = 0; i < 7; i++) step(8'h55, 1'b1);
        step(8'hD5, 1'b1);
        for (int i = 0; i < 20; i++) step(8'($urandom), 1'b1);
        sys_rst = 1'b1;
        repeat (3) step(8'($urandom), 1'b1);
        chk("t5_rst_pps", rx_pps, 32'd0);
        chk("t5_rst_lat", rx_latency, 32'd0);
        chk("t5_rst_ok", 32'(rx_frame_ok), 32'd0);
        sys_rst = 1'b0;
        for (int i = 0; i < 50; i++) step(8'($urandom), 1'b1);
        repeat (3) step(8'h00, 1'b0);
        send_frame(64, 7, 0, 0, 32'd7, 4, 0, 0);
        wait_win_start();
        chk("t5_pps", rx_pps, 32'd1);
        chk("t5_lat", rx_latency, 32'd7);

        // Corrupted preamble, then a clean frame.
        send_frame(64, 7, 1, 0, 32'd9, 4, 0, 0);
        send_frame(64, 7, 0, 0, 32'd11, 4, 0, 0);
        wait_win_start();
        chk("t6_pps", rx_pps, 32'd1);
        chk("t6_lat", rx_latency, 32'd11);

        // Length boundaries, then randomized traffic.
        send_frame(1518, 7, 0, 0, $urandom, 3, 0, 0);
        send_frame(1519, 7, 0, 0, $urandom, 3, 0, 0);
        for (int k = 0; k < 60; k++) begin
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(55, 70) : $urandom_range(60, 130);
            np  = $urandom_range(2, 7);
            bp  = ($urandom_range(0, 9) == 0) ? 1 : 0;
            cor = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0;
            send_frame(len, np, bp[0], cor, $urandom, $urandom_range(1, 6), 0, 0);
        end
        wait_win_start();
        wait_win_start();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
